// File: rtl/alu_writeback_stage.sv
// Writeback collector for the ALU sub-units: one op outstanding, first result wins,
// presented on a valid/ready port; owns the architectural Z/N/V/C flags register.
module alu_writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]       issue_dest,
  input  logic                            issue_set_flags,
  output logic                            issue_ready,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS*4-1:0]          unit_flags,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]       wb_dest,
  output logic [DATA_WIDTH-1:0]           wb_data,
  output logic [3:0]                      flags_q,
  output logic                            collide_err,
  output logic                            stray_err,
  output logic                            timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_pend_dest;
  logic                      r_pend_set_flags;
  logic [REG_ADDR_WIDTH-1:0] r_wb_dest;
  logic [DATA_WIDTH-1:0]     r_wb_data;
  logic [3:0]                r_hold_flags;
  logic                      r_hold_set_flags;
  logic [3:0]                r_flags;
  logic                      r_collide;
  logic                      r_stray;
  logic                      r_timeout;

  logic                      w_issue_ready;
  logic                      w_handshake;
  logic                      w_accept;
  logic                      w_window;
  logic                      w_any;
  logic                      w_multi;
  logic                      w_capture;
  logic                      w_expire;
  logic [DATA_WIDTH-1:0]     w_sel_data;
  logic [3:0]                w_sel_flags;

  // Lowest set index wins: scan high to low so the lowest assignment lands last.
  always_comb begin
    w_sel_data  = '0;
    w_sel_flags = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (unit_valid[i]) begin
        w_sel_data  = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_flags = unit_flags[i*4 +: 4];
      end
    end
  end

  assign w_accept  = issue_valid & w_issue_ready;
  assign w_any     = |unit_valid;
  assign w_multi   = |(unit_valid & (unit_valid - NUM_UNITS'(1)));
  assign w_window  = (r_state == S_WAIT) | w_accept;
  assign w_capture = w_window & w_any;
  assign w_expire  = (r_state == S_WAIT) & ~w_any & (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_capture ? S_HOLD : S_WAIT;
      S_WAIT: begin
        if (w_capture)     w_state_nxt = S_HOLD;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (wb_ready) begin
          if (w_accept) w_state_nxt = w_capture ? S_HOLD : S_WAIT;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is combinational so a drained HOLD can take the next op on the same edge.
  always_comb begin
    w_issue_ready = 1'b0;
    w_handshake   = 1'b0;
    unique case (r_state)
      S_IDLE: w_issue_ready = 1'b1;
      S_HOLD: begin
        w_issue_ready = wb_ready;
        w_handshake   = wb_ready;
      end
      default: ;
    endcase
    if (!reset_n) w_issue_ready = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt            <= '0;
      r_pend_dest      <= '0;
      r_pend_set_flags <= 1'b0;
      r_wb_dest        <= '0;
      r_wb_data        <= '0;
      r_hold_flags     <= '0;
      r_hold_set_flags <= 1'b0;
      r_flags          <= '0;
      r_collide        <= 1'b0;
      r_stray          <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_collide <= w_capture & w_multi;
      r_stray   <= w_any & ~w_window;
      r_timeout <= w_expire;
      if (w_accept) begin
        r_pend_dest      <= issue_dest;
        r_pend_set_flags <= issue_set_flags;
      end
      if (w_accept)               r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      // A capture in the issue cycle bypasses the pending registers.
      if (w_capture) begin
        r_wb_data        <= w_sel_data;
        r_hold_flags     <= w_sel_flags;
        r_wb_dest        <= w_accept ? issue_dest : r_pend_dest;
        r_hold_set_flags <= w_accept ? issue_set_flags : r_pend_set_flags;
      end
      if (w_handshake && r_hold_set_flags) r_flags <= r_hold_flags;
    end
  end

  assign issue_ready = w_issue_ready;
  assign wb_valid    = (r_state == S_HOLD);
  assign wb_dest     = r_wb_dest;
  assign wb_data     = r_wb_data;
  assign flags_q     = r_flags;
  assign collide_err = r_collide;
  assign stray_err   = r_stray;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed scenarios plus randomized ops,
// expected writebacks queued at issue time and popped by an independent monitor.
module tb_alu_writeback_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned NU = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               issue_valid = 1'b0;
  logic [AW-1:0]      issue_dest = '0;
  logic               issue_set_flags = 1'b0;
  logic               issue_ready;
  logic [NU-1:0]      unit_valid = '0;
  logic [NU*DW-1:0]   unit_result = '0;
  logic [NU*4-1:0]    unit_flags = '0;
  logic               wb_valid;
  logic               wb_ready = 1'b0;
  logic [AW-1:0]      wb_dest;
  logic [DW-1:0]      wb_data;
  logic [3:0]         flags_q;
  logic               collide_err;
  logic               stray_err;
  logic               timeout_err;

  alu_writeback_stage #(
    .DATA_WIDTH(DW), .NUM_UNITS(NU), .REG_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_set_flags(issue_set_flags),
    .issue_ready(issue_ready),
    .unit_valid(unit_valid), .unit_result(unit_result), .unit_flags(unit_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .flags_q(flags_q), .collide_err(collide_err), .stray_err(stray_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [3:0]    flags;
    logic          set_flags;
    logic          collide;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_flags = '0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         fresh = 1'b1;
  bit         chk_quiet = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: flags model and writeback scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("flags_q", flags_q, exp_flags);
      if (chk_quiet) begin
        chk("stray_err_quiet", stray_err, 0);
        chk("timeout_err_quiet", timeout_err, 0);
      end
      if (wb_valid) begin
        if (q.size() == 0) chk("wb_valid_unexpected", wb_valid, 0);
        else begin
          chk("wb_dest", wb_dest, q[0].dest);
          chk("wb_data", wb_data, q[0].data);
          chk("collide_err", collide_err, fresh ? q[0].collide : 1'b0);
          fresh = 1'b0;
          if (wb_ready) begin
            if (q[0].set_flags) exp_flags = q[0].flags;
            void'(q.pop_front());
            fresh = 1'b1;
          end
        end
      end else begin
        chk("collide_err_idle", collide_err, 0);
      end
    end
  end

  // Issue one op; the result mask m arrives 'delay' cycles after the issue cycle (0 = same cycle).
  task automatic issue_op(input logic [AW-1:0] dest, input logic sf, input logic [NU-1:0] m,
                          input int delay, input logic [NU*DW-1:0] res,
                          input logic [NU*4-1:0] fl);
    exp_t e;
    e.dest = dest;
    e.set_flags = sf;
    e.collide = ($countones(m) > 1);
    e.data = '0;
    e.flags = '0;
    for (int i = NU - 1; i >= 0; i--)
      if (m[i]) begin
        e.data = res[i*DW +: DW];
        e.flags = fl[i*4 +: 4];
      end
    issue_valid = 1'b1;
    issue_dest = dest;
    issue_set_flags = sf;
    unit_result = res;
    unit_flags = fl;
    unit_valid = (delay == 0) ? m : '0;
    if (delay == 0) q.push_back(e);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_dest = AW'($urandom);
    issue_set_flags = 1'($urandom);
    unit_valid = '0;
    if (delay > 0) begin
      repeat (delay - 1) begin
        wb_ready = 1'($urandom);
        #1;
        chk("wait_issue_ready", issue_ready, 0);
        chk("wait_wb_valid", wb_valid, 0);
        @(posedge clk); #1;
      end
      unit_valid = m;
      q.push_back(e);
      @(posedge clk); #1;
      unit_valid = '0;
    end
    chk("capture_latency", wb_valid, 1);
  endtask

  task automatic rand_txn();
    logic [NU*DW-1:0] res;
    logic [NU*4-1:0]  fl;
    logic [NU-1:0]    m;
    int               guard = 0;
    forever begin
      @(posedge clk); #1;
      issue_valid = 1'b0;
      unit_valid = '0;
      wb_ready = ($urandom_range(0, 99) < 60);
      #1;
      chk("issue_ready", issue_ready, (q.size() == 0) || wb_ready);
      if (issue_ready && $urandom_range(0, 4) != 0) break;
      if (++guard > 60) begin
        chk("issue_ready_bound", issue_ready, 1);
        return;
      end
    end
    for (int i = 0; i < NU; i++) begin
      res[i*DW +: DW] = $urandom;
      fl[i*4 +: 4] = 4'($urandom);
    end
    m = NU'($urandom_range(1, (1 << NU) - 1));
    issue_op(AW'($urandom), 1'($urandom), m, $urandom_range(0, 4), res, fl);
  endtask

  task automatic drain();
    int g = 0;
    issue_valid = 1'b0;
    unit_valid = '0;
    wb_ready = 1'b1;
    while (q.size() != 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    chk("drain_idle", wb_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NU*DW-1:0] res;
    logic [NU*4-1:0]  fl;

    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_errs", {collide_err, stray_err, timeout_err}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_issue_ready", issue_ready, 1);

    // Single-cycle extend unit (index 2).
    wb_ready = 1'b0;
    res = '0; fl = '0;
    res[2*DW +: DW] = 32'hFFFF_FF80;
    fl[2*4 +: 4] = 4'b0010;
    issue_op(4'd5, 1'b1, 4'b0100, 0, res, fl);
    chk("ext_wb_dest", wb_dest, 5);
    chk("ext_wb_data", wb_data, 32'hFFFF_FF80);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    #1;
    chk("ext_flags_commit", flags_q, 4'b0010);
    chk("ext_idle_ready", issue_ready, 1);
    chk("ext_idle_valid", wb_valid, 0);

    // Registered unit 0 with three cycles of backpressure; set_flags=0.
    @(posedge clk); #1;
    res = '0; fl = '0;
    res[0 +: DW] = 32'h0000_FFFF;
    fl[0 +: 4] = 4'b1101;
    issue_op(4'd3, 1'b0, 4'b0001, 1, res, fl);
    repeat (3) begin
      #1;
      chk("bp_issue_ready", issue_ready, 0);
      chk("bp_wb_data", wb_data, 32'h0000_FFFF);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_flags_unchanged", flags_q, 4'b0010);
    chk("bp_idle", wb_valid, 0);

    // Back-to-back: new op issued in the handshake cycle.
    wb_ready = 1'b0;
    res = '0; fl = '0;
    res[0 +: DW] = 32'h0000_0009;
    issue_op(4'd9, 1'b0, 4'b0001, 0, res, fl);
    wb_ready = 1'b1;
    #1;
    chk("b2b_issue_ready", issue_ready, 1);
    res = '0; fl = '0;
    res[1*DW +: DW] = 32'h0000_0012;
    fl[1*4 +: 4] = 4'b0100;
    issue_op(4'd7, 1'b1, 4'b0010, 0, res, fl);
    chk("b2b_wb_dest", wb_dest, 7);
    chk("b2b_wb_data", wb_data, 32'h12);

    // Collision, again back-to-back; unit 0 must win.
    res = '0; fl = '0;
    res[0 +: DW] = 32'hA5A5_0000;
    res[1*DW +: DW] = 32'h5A5A_0000;
    fl[0 +: 4] = 4'b1000;
    fl[1*4 +: 4] = 4'b0001;
    issue_op(4'd2, 1'b1, 4'b0011, 0, res, fl);
    chk("col_pulse", collide_err, 1);
    chk("col_wb_data", wb_data, 32'hA5A5_0000);
    @(posedge clk); #1;
    chk("col_pulse_end", collide_err, 0);
    drain();

    // Result in the last WAIT cycle beats the timeout.
    res = '0; fl = '0;
    res[3*DW +: DW] = 32'hDEAD_BEEF;
    fl[3*4 +: 4] = 4'b0110;
    issue_op(4'd11, 1'b1, 4'b1000, TO, res, fl);
    drain();

    // Timeout followed by a late (stray) result.
    chk_quiet = 1'b0;
    issue_valid = 1'b1;
    issue_dest = 4'd4;
    issue_set_flags = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      wb_ready = 1'($urandom);
      #1;
      chk("to_wait_ready", issue_ready, 0);
      chk("to_wait_valid", wb_valid, 0);
      chk("to_early", timeout_err, 0);
      @(posedge clk); #1;
    end
    chk("to_pulse", timeout_err, 1);
    chk("to_no_wb", wb_valid, 0);
    chk("to_idle_ready", issue_ready, 1);
    unit_valid = 4'b0001;
    @(posedge clk); #1;
    unit_valid = '0;
    chk("stray_pulse", stray_err, 1);
    chk("stray_no_wb", wb_valid, 0);
    chk("to_pulse_end", timeout_err, 0);
    @(posedge clk); #1;
    chk("stray_pulse_end", stray_err, 0);
    chk_quiet = 1'b1;

    repeat (300) rand_txn();
    drain();

    // Async reset in the middle of HOLD.
    wb_ready = 1'b0;
    res = '0; fl = '0;
    res[0 +: DW] = 32'h1234_5678;
    fl[0 +: 4] = 4'b1111;
    issue_op(4'd6, 1'b1, 4'b0001, 0, res, fl);
    #2;
    reset_n = 1'b0;
    q.delete();
    exp_flags = '0;
    fresh = 1'b1;
    #1;
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_flags_q", flags_q, 0);
    chk("arst_issue_ready", issue_ready, 0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    chk("arst_release_ready", issue_ready, 1);

    repeat (20) rand_txn();
    drain();
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Downstream collector for the ALU sub-units (arith, logic, shift, extend). It accepts one issued ALU op at a time and records the destination register and whether flags update. It captures the first sub-unit result/result_valid/result_flags that arrives, then presents it on a valid/ready writeback port to the register file. It also owns the architectural 4-bit flags register, which commits on the writeback handshake.

Parameters:
DATA_WIDTH, 32, width of result and writeback data
NUM_UNITS, 4, number of ALU sub-units feeding this stage; index 0 has highest priority
REG_ADDR_WIDTH, 4, destination register index width
TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the op is abandoned; must be >= 2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  ALU op issued this cycle
issue_dest  in  REG_ADDR_WIDTH  destination register of issued op
issue_set_flags  in  1  op updates flags_q on commit
issue_ready  out  1  stage can accept an issue this cycle
unit_valid  in  NUM_UNITS  per-unit result_valid
unit_result  in  NUM_UNITS*DATA_WIDTH  per-unit result; unit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
unit_flags  in  NUM_UNITS*4  per-unit result_flags; bit0 Z, bit1 N, bit2 V, bit3 C
wb_valid  out  1  writeback data valid
wb_ready  in  1  register file accepts writeback
wb_dest  out  REG_ADDR_WIDTH  writeback register index
wb_data  out  DATA_WIDTH  writeback data
flags_q  out  4  architectural flags register
collide_err  out  1  one-cycle pulse: more than one unit_valid bit set in a capture cycle
stray_err  out  1  one-cycle pulse: unit_valid seen with no op outstanding
timeout_err  out  1  one-cycle pulse: op abandoned after TIMEOUT_CYCLES

Behaviour:
- Reset: clk is the single clock. reset_n is asynchronous and active-low. While reset_n is low:
  - state is IDLE and the timeout counter is 0
  - wb_valid, wb_dest, wb_data, flags_q, and all err outputs are 0
  - issue_ready is forced 0
- Reset mid-operation discards any pending op and held result without writeback.
- States:
  - IDLE: no op outstanding.
  - WAIT: op accepted, no result yet.
  - HOLD: result registered, wb_valid=1.
- issue_ready is combinational: 1 in IDLE, or in HOLD when wb_ready=1 (back-to-back). It is 0 in WAIT.
- Issue accept = issue_valid && issue_ready. issue_dest and issue_set_flags are latched into pending registers.
- Capture window: state WAIT, or the issue-accept cycle itself. Single-cycle units return result_valid in the issue cycle.
- Capture in the window with any unit_valid bit high:
  - select the lowest set index i
  - register unit_result[i] into wb_data and unit_flags[i] into the held flags
  - wb_dest takes the pending dest, or issue_dest if captured in the issue cycle
  - set_flags is taken the same way
  - next state HOLD; wb_valid is high from the following cycle
  - latency is 1 cycle from unit_valid to wb_valid
- collide_err pulses the cycle after a capture in which popcount(unit_valid) > 1. The data from the lowest index is still used.
- unit_valid high outside the capture window (IDLE with no issue, or HOLD) is ignored. stray_err pulses the next cycle.
- HOLD: wb_valid, wb_dest and wb_data stay stable until wb_ready=1.
  - On the handshake, if the held set_flags=1, flags_q <= held flags the same edge; otherwise flags_q is unchanged.
  - Next state: IDLE, or WAIT/HOLD if a new issue is accepted the same cycle, with capture rules as above.
- Timeout counter clears on issue accept and increments each cycle in WAIT. When it reaches TIMEOUT_CYCLES-1 with no unit_valid: return to IDLE, pulse timeout_err, no writeback, flags unchanged. unit_valid in that same cycle wins over the timeout.
- wb_ready while wb_valid=0 has no effect.
- Strictly one op outstanding; there is no buffering beyond the HOLD register.

Test Plan:
- Single-cycle extend unit (index 2):
  - Stimulus: issue dest=5, set_flags=1; unit_valid=0b0100 in the same cycle with result 0xFFFFFF80, flags 0b0010.
  - Required: wb_valid=1 next cycle, wb_dest=5, wb_data=0xFFFFFF80. With wb_ready=1, flags_q=0b0010 after the edge and state returns to IDLE.
- Registered unit plus backpressure:
  - Stimulus: issue dest=3, set_flags=0; unit0 valid one cycle later, result 0x0000FFFF; wb_ready held low 3 cycles.
  - Required: wb_valid held 3 cycles with stable data and issue_ready=0. After wb_ready=1, flags_q is unchanged.
- Back-to-back:
  - Stimulus: in HOLD with wb_ready=1, issue dest=7 and unit1 valid 0x12 in the same cycle.
  - Required: next cycle wb_dest=7, wb_data=0x12, wb_valid=1 continuously, no bubble.
- Collision:
  - Stimulus: unit_valid=0b0011 in the capture window.
  - Required: wb_data is unit0's result; collide_err pulses 1 cycle.
- Timeout and stray:
  - Stimulus: issue with no unit_valid for 16 cycles, then unit_valid while IDLE.
  - Required: timeout_err pulses after the 16th WAIT cycle and wb_valid never rises. stray_err pulses for the late result.
- Async reset:
  - Stimulus: drop reset_n mid-HOLD, between clock edges.
  - Required: wb_valid=0, flags_q=0 and issue_ready=0 immediately. issue_ready=1 on the first cycle after release.
